download_packer: RTL

DOWNLOAD_PACKER -- requirements
Module: download_packer

---
 rtl/download_packer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/download_packer.sv
// Packs the HPS byte-wide ROM download into 32-bit little-endian SDRAM words
// through a one-word accumulator, a two-entry word FIFO and a req/ack issuer.
module download_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        done,
  output logic        overflow
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } word_t;

  // Download framing and status
  logic        dl_q;
  logic        seen_q, seen_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        dl_rise;

  // Accumulator
  logic [22:0] acc_tag_q, acc_tag_d;
  logic [31:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_mask_q, acc_mask_d;

  // Word FIFO
  word_t       fifo_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  free;
  logic [1:0]  push_cnt;
  word_t       push_a, push_b;

  // Issuer
  state_e      state_q, state_d;
  logic [22:0] addr_q;
  logic [31:0] data_q;
  logic        fsm_req, load_head, pop;

  // Byte-path intermediates
  logic [22:0] base_tag, wr_tag;
  logic [31:0] base_data, start_data, merged_data;
  logic [3:0]  base_mask, start_mask, merged_mask;
  logic [1:0]  wr_lane, wr_pushes;
  logic        wr_en, need_flush, lane3, drop, end_flush;

  assign dl_rise = ioctl_download & ~dl_q;

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order these processes run in.
    if (reset) begin
      dl_q   <= 1'b0;
      seen_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      seen_q <= seen_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    base_mask   = dl_rise ? 4'h0 : acc_mask_q;
    base_data   = dl_rise ? 32'h0 : acc_data_q;
    base_tag    = acc_tag_q;
    wr_tag      = ioctl_addr[24:2];
    wr_lane     = ioctl_addr[1:0];
    wr_en       = ioctl_wr & ioctl_download;
    free        = 2'd2 - count_q + {1'b0, pop};

    need_flush  = (base_mask != 4'h0) && (base_tag != wr_tag);
    start_mask  = need_flush ? 4'h0 : base_mask;
    start_data  = need_flush ? 32'h0 : base_data;
    merged_data = start_data;
    merged_data[{wr_lane, 3'b000} +: 8] = ioctl_data;
    merged_mask = start_mask | (4'b0001 << wr_lane);
    lane3       = (wr_lane == 2'd3);
    wr_pushes   = {1'b0, need_flush} + {1'b0, lane3};
    drop        = wr_en && (wr_pushes > free);
    end_flush   = ~ioctl_download && (acc_mask_q != 4'h0) && (free != 2'd0);

    acc_tag_d   = acc_tag_q;
    acc_data_d  = base_data;
    acc_mask_d  = base_mask;
    push_cnt    = 2'd0;
    push_a      = '0;
    push_b      = '0;
    ovf_d       = dl_rise ? 1'b0 : ovf_q;

    if (wr_en) begin
      if (drop) begin
        ovf_d = 1'b1;
      end else begin
        if (need_flush) begin
          push_a   = '{addr: base_tag, data: base_data};
          push_cnt = 2'd1;
        end
        if (lane3) begin
          // The completing byte travels with its word; the accumulator empties.
          if (need_flush) push_b = '{addr: wr_tag, data: merged_data};
          else            push_a = '{addr: wr_tag, data: merged_data};
          push_cnt   = push_cnt + 2'd1;
          acc_mask_d = 4'h0;
          acc_data_d = 32'h0;
        end else begin
          acc_tag_d  = wr_tag;
          acc_mask_d = merged_mask;
          acc_data_d = merged_data;
        end
      end
    end else if (end_flush) begin
      push_a     = '{addr: acc_tag_q, data: acc_data_q};
      push_cnt   = 2'd1;
      acc_mask_d = 4'h0;
      acc_data_d = 32'h0;
    end

    count_d  = count_q - {1'b0, pop} + push_cnt;
    wr_ptr_d = wr_ptr_q ^ push_cnt[0];
    rd_ptr_d = rd_ptr_q ^ pop;

    seen_d = seen_q | dl_rise;
    done_d = dl_rise ? 1'b0
           : done_q | (seen_q && !ioctl_download && (acc_mask_q == 4'h0) &&
                       (count_q == 2'd0) && (state_q == S_IDLE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_tag_q  <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      acc_tag_q  <= acc_tag_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is deliberately left out of reset; the reset
  // pointers and count make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) fifo_q[wr_ptr_q]  <= push_a;
    if (push_cnt == 2'd2) fifo_q[~wr_ptr_q] <= push_b;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != 2'd0) state_d = S_REQ;
      S_REQ:   if (sdram_ack)       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fsm_req   = (state_q == S_REQ);
    load_head = (state_q == S_IDLE) && (count_q != 2'd0);
    pop       = (state_q == S_REQ) && sdram_ack;
  end

  // Head word is captured on entry to S_REQ and held until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load_head) begin
      addr_q <= fifo_q[rd_ptr_q].addr;
      data_q <= fifo_q[rd_ptr_q].data;
    end
  end

  assign sdram_req  = fsm_req & ~reset;
  assign sdram_we   = sdram_req;
  assign sdram_addr = reset ? 23'h0 : addr_q;
  assign sdram_data = reset ? 32'h0 : data_q;
  assign ioctl_wait = ~reset & ((count_q == 2'd2) ||
                                ((count_q == 2'd1) && (acc_mask_q != 4'h0)));
  assign done       = done_q & ~reset;
  assign overflow   = ovf_q & ~reset;

endmodule
